// File: rtl/uart_pkg.sv
// Shared types and register map for the Wishbone UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 8;

    // The fill field is 8 bits wide; a 256-deep FIFO saturates it at 255.
    function automatic logic [7:0] fill_field(input logic [8:0] count);
        return count[8] ? 8'hFF : count[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output; caller gates push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_rx_wb.sv
// Wishbone B4 classic UART receiver: 8N1 deserializer, receive FIFO, status/control registers, level irq.
module uart_rx_wb
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack,
    input  logic        rx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta, rx_s, rx_prev, fall;
    logic [1:0]    warm;
    rx_state_t     state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          stop_ok, stop_bad;

    logic          fifo_full, fifo_empty, push, pop;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic          req, rd, wr, ovr_set, ovr_clr, ferr_clr;
    logic [1:0]    sel;
    logic [31:0]   rd_data;
    logic          overrun, frame_err, irq_en;
    logic          unused_bits;

    // rx_prev only holds a genuinely sampled level, so a line already low at reset release is not a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            warm    <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            warm    <= {warm[0], 1'b1};
            rx_prev <= rx_s & warm[1];
        end
    end

    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            idx   <= 3'd0;
            shift <= 8'd0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            shift <= shift_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        idx_n    = idx;
        shift_n  = shift;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    timer_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_n = '0;
                    idx_n   = 3'd0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_n        = '0;
                    shift_n[idx]   = rx_s;
                    idx_n          = idx + 3'd1;
                    state_n        = (idx == 3'd7) ? STOP : DATA;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            STOP: begin
                if (timer == BIT_LAST) begin
                    timer_n  = '0;
                    state_n  = IDLE;
                    stop_ok  = rx_s;
                    stop_bad = ~rx_s;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    assign req  = cyc & stb & ~ack;
    assign rd   = req & ~we;
    assign wr   = req & we;
    assign sel  = adr[3:2];

    // A pop frees a slot in the same cycle, so a stop bit landing on a full FIFO then is not an overrun.
    assign pop      = rd & (sel == REG_RXDATA) & ~fifo_empty;
    assign push     = stop_ok & (~fifo_full | pop);
    assign ovr_set  = stop_ok & fifo_full & ~pop;
    assign ovr_clr  = wr & (sel == REG_STATUS) & dat_i[ST_OVERRUN];
    assign ferr_clr = wr & (sel == REG_STATUS) & dat_i[ST_FRAME_ERR];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shift),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rd_data = 32'd0;
        case (sel)
            REG_RXDATA: begin
                if (fifo_empty) begin
                    rd_data = 32'd0;
                end else begin
                    rd_data = {23'd0, 1'b1, fifo_dout};
                end
            end
            REG_STATUS: begin
                rd_data[ST_NOT_EMPTY]        = ~fifo_empty;
                rd_data[ST_FULL]             = fifo_full;
                rd_data[ST_OVERRUN]          = overrun;
                rd_data[ST_FRAME_ERR]        = frame_err;
                rd_data[ST_COUNT_LSB +: 8]   = fill_field(9'(fifo_count));
            end
            REG_CTRL: rd_data = {31'd0, irq_en};
            default:  rd_data = 32'd0;
        endcase
    end

    // Set events take priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack       <= 1'b0;
            dat_o     <= 32'd0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            ack       <= req;
            dat_o     <= rd ? rd_data : 32'd0;
            overrun   <= ovr_set  | (overrun   & ~ovr_clr);
            frame_err <= stop_bad | (frame_err & ~ferr_clr);
            irq_en    <= (wr && sel == REG_CTRL) ? dat_i[0] : irq_en;
            irq       <= irq_en & (~fifo_empty | overrun | frame_err);
        end
    end

    assign unused_bits = ^{adr[31:4], adr[1:0], dat_i[31:4], dat_i[1]};

endmodule

// File: tb/tb_uart_rx_wb.sv
// Self-checking bench: serial frames in, Wishbone reads out, compared against a queue-based model.
module tb_uart_rx_wb;
    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, ack, rx, irq;
    logic [31:0] adr, dat_i, dat_o;

    int total = 0;
    int bad   = 0;

    byte unsigned q[$];
    bit m_ovr, m_ferr, m_en;

    always #5 clk = ~clk;

    uart_rx_wb #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
        .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .rx(rx), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'd0;
        s[0]    = (q.size() != 0);
        s[1]    = (q.size() == DEPTH);
        s[2]    = m_ovr;
        s[3]    = m_ferr;
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    function automatic logic exp_irq();
        return m_en & ((q.size() != 0) | m_ovr | m_ferr);
    endfunction

    task automatic bus(input logic [1:0] r, input logic w, input logic [31:0] wdata,
                       output logic [31:0] d, output int lat);
        @(negedge clk);
        adr = {28'd0, r, 2'b00}; we = w; dat_i = wdata; cyc = 1'b1; stb = 1'b1;
        lat = 0; d = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (ack === 1'b1) begin
                d = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_check(input logic [1:0] r, input string tag);
        logic [31:0] d, e;
        int lat;
        case (r)
            2'd0:    e = (q.size() != 0) ? {23'd0, 1'b1, q[0]} : 32'd0;
            2'd1:    e = exp_status();
            2'd2:    e = {31'd0, m_en};
            default: e = 32'd0;
        endcase
        bus(r, 1'b0, 32'd0, d, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check(tag, d, e);
        if (r == 2'd0 && q.size() != 0) void'(q.pop_front());
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] data);
        logic [31:0] d;
        int lat;
        bus(r, 1'b1, data, d, lat);
        check("wr_lat", 32'(lat), 32'd1);
        if (r == 2'd1) begin
            if (data[2]) m_ovr = 1'b0;
            if (data[3]) m_ferr = 1'b0;
        end
        if (r == 2'd2) m_en = data[0];
    endtask

    task automatic send(input logic [7:0] b, input bit stop_good);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_good;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        if (!stop_good) m_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic check_irq(input string tag);
        repeat (2) @(negedge clk);
        check(tag, {31'd0, irq}, {31'd0, exp_irq()});
    endtask

    initial begin
        logic [7:0] b;
        bit good;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat_i = 32'd0; rx = 1'b1;
        m_ovr = 1'b0; m_ferr = 1'b0; m_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        rd_check(2'd0, "empty_rxdata");
        rd_check(2'd1, "empty_status");

        send(8'hA5, 1'b1);
        check("a5_model", exp_status(), 32'h0000_0101);
        rd_check(2'd1, "a5_status");
        rd_check(2'd0, "a5_data");
        rd_check(2'd1, "a5_status_after");

        for (int i = 0; i < 17; i++) send(8'(i), 1'b1);
        rd_check(2'd1, "full_status");
        wb_write(2'd1, 32'h4);
        rd_check(2'd1, "ovr_cleared");
        for (int i = 0; i < 16; i++) rd_check(2'd0, "drain");
        rd_check(2'd0, "drain_empty");
        rd_check(2'd1, "drain_status");

        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rd_check(2'd1, "glitch_status");

        send(8'h5A, 1'b0);
        rd_check(2'd1, "ferr_status");
        wb_write(2'd1, 32'h8);
        rd_check(2'd1, "ferr_cleared");

        wb_write(2'd2, 32'h1);
        rd_check(2'd2, "ctrl_rd");
        check_irq("irq_idle");
        send(8'h3C, 1'b1);
        check_irq("irq_data");
        rd_check(2'd0, "irq_rd");
        check_irq("irq_fall");
        send(8'hC3, 1'b1);
        check_irq("irq_again");
        wb_write(2'd2, 32'h0);
        check_irq("irq_masked");
        rd_check(2'd0, "masked_rd");

        // Reset in the middle of 0x55's data bits with the line left low across release.
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1; repeat (CPB) @(negedge clk);
        rx = 1'b0; repeat (CPB) @(negedge clk);
        rx = 1'b1; repeat (CPB) @(negedge clk);
        rx = 1'b0; repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        q.delete(); m_ovr = 1'b0; m_ferr = 1'b0; m_en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rd_check(2'd1, "post_rst_status");
        rd_check(2'd2, "post_rst_ctrl");
        send(8'h81, 1'b1);
        check("post_rst_model", {23'd0, 1'b1, q[0]}, 32'h0000_0181);
        rd_check(2'd0, "post_rst_data");
        rd_check(2'd0, "post_rst_empty");

        for (int it = 0; it < 25; it++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            send(b, good);
            case ($urandom_range(0, 4))
                0: rd_check(2'd1, "rnd_status");
                1: rd_check(2'd0, "rnd_data");
                2: wb_write(2'd1, $urandom);
                3: begin
                    wb_write(2'($urandom_range(0, 1) * 3), $urandom);
                    rd_check(2'd3, "rnd_reg3");
                    rd_check(2'd1, "rnd_status_after_ignored");
                end
                default: wb_write(2'd2, 32'($urandom_range(0, 1)));
            endcase
            check_irq("rnd_irq");
        end
        while (q.size() != 0) rd_check(2'd0, "final_drain");
        rd_check(2'd1, "final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_wb.md
Name: uart_rx_wb

Overview:
- Wishbone B4 classic slave UART receiver. It is the receive-side counterpart of the transmit-only console peripheral.
- Samples the asynchronous `rx` pin as 8N1 frames and buffers received bytes in a FIFO.
- Exposes data, status and control registers to the CPU data bus through the cross bar.
- Raises a level interrupt while data is pending.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per bit period (clk/baud); minimum 8.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  bus clock (same as WB4 clock)
- rst  input  1  asynchronous active-high reset
- cyc  input  1  Wishbone cycle
- stb  input  1  Wishbone strobe
- we  input  1  Wishbone write enable
- adr  input  32  byte address; only adr[3:2] decoded
- dat_i  input  32  write data
- dat_o  output  32  read data
- ack  output  1  Wishbone acknowledge
- rx  input  1  serial input, idle high, asynchronous to clk
- irq  output  1  interrupt request, level

Behaviour:
- Reset (async, rst=1) clears the following:
  - ack=0, dat_o=0, irq=0, FSM=IDLE, FIFO empty.
  - overrun=0, frame_err=0, irq_en=0.
  - Both synchronizer flops set to 1.
- Input sync: 2-FF synchronizer on rx. All decisions use the synchronized value rx_s.
- RX FSM states are IDLE, START, DATA, STOP, with a bit-timer counter and a 3-bit bit index.
  - IDLE: stays while rx_s=1. Falling edge of rx_s -> START, timer=0.
  - START: at timer=CLKS_PER_BIT/2-1, sample rx_s.
    - rx_s=1 -> false start, go to IDLE.
    - rx_s=0 -> DATA, timer=0, index=0.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[index], LSB first. After index 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rx_s=1 with FIFO not full: push byte.
    - rx_s=1 with FIFO full: byte dropped, overrun=1.
    - rx_s=0: frame_err=1, byte discarded.
    - In every case -> IDLE. IDLE needs a fresh falling edge, so a held-low break produces exactly one frame error.
- Push latency: byte is visible in STATUS.valid the cycle after the stop-bit sample.
- Registers (adr[3:2]):
  - 0 RXDATA (RO).
    - Read returns {23'b0, valid, byte}.
    - If valid=1, the FIFO pops on the ack cycle.
    - If empty, reads 0x0000_0000 and does not pop.
    - Writes are ignored.
  - 1 STATUS.
    - bit0 not_empty (RO), bit1 full (RO), bit2 overrun, bit3 frame_err, bits[15:8] fill count.
    - Writing 1 to bit2 or bit3 clears that bit (W1C).
    - A set event in the same cycle as a W1C wins; the bit stays 1.
  - 2 CTRL (RW): bit0 irq_en. Other bits read 0.
  - 3: reads 0, writes ignored.
- Wishbone: ack <= cyc & stb & ~ack.
  - Exactly one cycle after request, and one ack per strobe.
  - dat_o is registered and valid with ack.
  - Pops and W1C take effect on the ack cycle.
  - cyc dropping before ack: the transaction aborts, with no side effects.
- irq = irq_en & (not_empty | overrun | frame_err), registered.
- Simultaneous push and pop:
  - Full: pop and push both occur, no overrun, count unchanged.
  - Empty: RXDATA read returns 0; the push completes.
- Reset mid-frame: FSM returns to IDLE and the partial byte is discarded. After release, a low rx is not treated as a start until a falling edge is seen.
- Count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, STOP).
  - Register index constants REG_RXDATA=0, REG_STATUS=1, REG_CTRL=2.
  - STATUS bit position constants.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH).
  - Ports: clk, rst, push, din, pop, dout, full, empty, count.
  - dout shows the head entry combinationally (first-word fall-through).
  - It has no protection; the caller gates push/pop.

Test Plan:
- Send 0xA5 at CLKS_PER_BIT=16 -> STATUS reads 0x0000_0101; RXDATA reads 0x0000_01A5; STATUS then 0x0000_0000.
- Read RXDATA with FIFO empty -> 0x0000_0000 and ack exactly 1 cycle after stb; count stays 0.
- 17 bytes 0x00..0x10 with no reads (DEPTH 16) -> STATUS bit1=1, bit2=1, count=16; reads return 0x100..0x10F. Write 0x4 to STATUS -> bit2 clears.
- Glitch: rx low for 3 cycles, then high -> no push, no frame error. Frame sent with stop bit 0 -> frame_err=1, FIFO empty.
- CTRL=1, then send 0x3C -> irq rises 1 cycle after not_empty. Read RXDATA -> irq falls; CTRL=0 masks irq.
- Assert rst during DATA of 0x55, release, send 0x81 -> only 0x181 is read back.
